// File: rtl/pf_ingress_pkg.sv
// Shared FSM state encoding and default widths for the packet ingress writer.
package pf_ingress_pkg;

    localparam int unsigned W_DATA     = 8;
    localparam int unsigned ADDR_WIDTH = 11;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_REWIND  = 2'd3
    } state_e;

endpackage

// File: rtl/pkt_ingress_writer_if.sv
// Upstream beat stream: valid/ready handshake with sof/eof framing and filter verdict.
interface pkt_ingress_writer_if #(
    parameter int unsigned W_DATA = pf_ingress_pkg::W_DATA
);
    logic              s_valid;
    logic              s_ready;
    logic [W_DATA-1:0] s_data;
    logic              s_sof;
    logic              s_eof;
    logic              s_drop;

    modport master (
        output s_valid, s_data, s_sof, s_eof, s_drop,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_data, s_sof, s_eof, s_drop,
        output s_ready
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that increments on inc and holds at all-ones instead of wrapping.
module sat_counter
    import pf_ingress_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pkt_ingress_writer.sv
// Writes filtered packets into a sync FIFO, publishing the write pointer only on
// packet commit and rewinding the FIFO write pointer on drop or overflow.
module pkt_ingress_writer #(
    parameter int unsigned ADDR_WIDTH = pf_ingress_pkg::ADDR_WIDTH,
    parameter int unsigned W_DATA     = pf_ingress_pkg::W_DATA
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pkt_ingress_writer_if.slave   s,
    output logic                  fifo_wen,
    output logic [W_DATA:0]       fifo_wdata,
    input  logic                  fifo_full,
    output logic                  fifo_wrst,
    output logic [ADDR_WIDTH:0]   fifo_rst_wptr,
    output logic [ADDR_WIDTH:0]   commit_wptr,
    output logic                  commit_pulse,
    output logic [15:0]           pkt_count,
    output logic [15:0]           drop_count
);
    import pf_ingress_pkg::*;

    localparam int unsigned PW = ADDR_WIDTH + 1;

    state_e        state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] start_ptr;
    logic          s_ready_q;

    logic accept_c;
    logic start_c;
    logic commit_c;
    logic drop_inc_c;

    // Ready is a pure function of state (held low only during the rewind cycle).
    assign s.s_ready = s_ready_q;
    assign accept_c  = s.s_valid && s_ready_q;
    assign start_c   = accept_c && (state == ST_IDLE) && s.s_sof;

    assign fifo_wen = accept_c && !fifo_full && !(s.s_eof && s.s_drop) &&
                      ((state == ST_RECV) || ((state == ST_IDLE) && s.s_sof));
    assign fifo_wdata    = {s.s_eof, s.s_data};
    assign fifo_rst_wptr = start_ptr;

    assign commit_c   = fifo_wen && s.s_eof;
    // Single-beat packets rejected in IDLE never reach REWIND, so count them here.
    assign drop_inc_c = (state == ST_REWIND) ||
                        (start_c && s.s_eof && (fifo_full || s.s_drop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            start_ptr    <= '0;
            commit_wptr  <= '0;
            commit_pulse <= 1'b0;
            fifo_wrst    <= 1'b0;
            s_ready_q    <= 1'b1;
        end else begin
            commit_pulse <= commit_c;
            fifo_wrst    <= 1'b0;
            s_ready_q    <= 1'b1;

            if (commit_c) commit_wptr <= PW'(wr_ptr + PW'(1));
            if (start_c)  start_ptr   <= wr_ptr;

            if (state == ST_REWIND) wr_ptr <= start_ptr;
            else if (fifo_wen)      wr_ptr <= PW'(wr_ptr + PW'(1));

            case (state)
                ST_IDLE: begin
                    if (start_c && !s.s_eof) state <= fifo_full ? ST_DISCARD : ST_RECV;
                end
                ST_RECV: begin
                    if (accept_c && s.s_eof) begin
                        if (commit_c) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_REWIND;
                            fifo_wrst <= 1'b1;
                            s_ready_q <= 1'b0;
                        end
                    end else if (accept_c && fifo_full) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (accept_c && s.s_eof) begin
                        state     <= ST_REWIND;
                        fifo_wrst <= 1'b1;
                        s_ready_q <= 1'b0;
                    end
                end
                ST_REWIND: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    sat_counter u_pkt_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (commit_c),
        .count   (pkt_count)
    );

    sat_counter u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (drop_inc_c),
        .count   (drop_count)
    );
endmodule

// File: tb/tb_pkt_ingress_writer.sv
// Directed bench for pkt_ingress_writer at ADDR_WIDTH=3 with a write scoreboard.
module tb_pkt_ingress_writer;

    logic        clk;
    logic        reset_n;
    logic        fifo_wen;
    logic [8:0]  fifo_wdata;
    logic        fifo_full;
    logic        fifo_wrst;
    logic [3:0]  fifo_rst_wptr;
    logic [3:0]  commit_wptr;
    logic        commit_pulse;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [8:0] exp_q[$];
    logic [3:0] exp_ptr;
    logic [3:0] pkt_start;
    logic [3:0] exp_commit;
    logic [15:0] exp_pkt;
    logic [15:0] exp_drop;

    pkt_ingress_writer_if #(.W_DATA(8)) bus ();

    pkt_ingress_writer #(.ADDR_WIDTH(3), .W_DATA(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s             (bus.slave),
        .fifo_wen      (fifo_wen),
        .fifo_wdata    (fifo_wdata),
        .fifo_full     (fifo_full),
        .fifo_wrst     (fifo_wrst),
        .fifo_rst_wptr (fifo_rst_wptr),
        .commit_wptr   (commit_wptr),
        .commit_pulse  (commit_pulse),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Scoreboard: every write seen at the FIFO must match the next expected beat.
    always @(negedge clk) begin
        if (reset_n && fifo_wen) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $error("FAIL wen_unexpected observed=0x%0h expected=none", fifo_wdata);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                assert (fifo_wdata === e) n_pass++;
                else $error("FAIL wdata observed=0x%0h expected=0x%0h", fifo_wdata, e);
            end
        end
    end

    task automatic beat(input logic sof, input logic eof, input logic drop,
                        input logic full, input logic [7:0] d, input bit wr);
        chk("s_ready_before_beat", 32'(bus.s_ready), 32'd1);
        bus.s_valid = 1'b1;
        bus.s_sof   = sof;
        bus.s_eof   = eof;
        bus.s_drop  = drop;
        bus.s_data  = d;
        fifo_full   = full;
        if (sof) pkt_start = exp_ptr;
        if (wr) begin
            exp_q.push_back({eof, d});
            exp_ptr = exp_ptr + 4'd1;
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_eof   = 1'b0;
        bus.s_drop  = 1'b0;
        fifo_full   = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic commit_check(input string tag);
        exp_commit = exp_ptr;
        if (exp_pkt != 16'hFFFF) exp_pkt = exp_pkt + 16'd1;
        chk({tag, "_pulse"}, 32'(commit_pulse), 32'd1);
        chk({tag, "_wptr"}, 32'(commit_wptr), 32'(exp_commit));
        chk({tag, "_pkt"}, 32'(pkt_count), 32'(exp_pkt));
    endtask

    initial begin
        reset_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_eof = 1'b0;
        bus.s_drop = 1'b0; bus.s_data = '0; fifo_full = 1'b0;
        exp_ptr = '0; pkt_start = '0; exp_commit = '0; exp_pkt = '0; exp_drop = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_commit_wptr", 32'(commit_wptr), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_pulse", 32'(commit_pulse), 32'd0);
        chk("rst_wrst", 32'(fifo_wrst), 32'd0);
        chk("rst_rst_wptr", 32'(fifo_rst_wptr), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        idle();

        // Four-beat packet committed
        beat(1, 0, 0, 0, 8'h11, 1);
        beat(0, 0, 0, 0, 8'h12, 1);
        beat(0, 0, 0, 0, 8'h13, 1);
        chk("mid_pkt_no_commit", 32'(commit_wptr), 32'd0);
        beat(0, 1, 0, 0, 8'h14, 1);
        commit_check("pkt4");
        idle();
        chk("pkt4_pulse_one_cycle", 32'(commit_pulse), 32'd0);

        // Non-sof beat in IDLE is swallowed
        beat(0, 0, 0, 0, 8'h99, 0);
        chk("idle_nosof_no_commit", 32'(commit_pulse), 32'd0);
        chk("idle_nosof_wptr", 32'(commit_wptr), 32'(exp_commit));

        // Filter drop on eof rewinds to packet start
        beat(1, 0, 0, 0, 8'h21, 1);
        beat(0, 0, 0, 0, 8'h22, 1);
        beat(0, 1, 1, 0, 8'h23, 0);
        chk("drop_wrst", 32'(fifo_wrst), 32'd1);
        chk("drop_rst_wptr", 32'(fifo_rst_wptr), 32'd4);
        chk("drop_ready_low", 32'(bus.s_ready), 32'd0);
        chk("drop_commit_hold", 32'(commit_wptr), 32'd4);
        chk("drop_cnt_before", 32'(drop_count), 32'd0);
        idle();
        exp_ptr = pkt_start; exp_drop = exp_drop + 16'd1;
        chk("drop_cnt", 32'(drop_count), 32'(exp_drop));
        chk("drop_wrst_one_cycle", 32'(fifo_wrst), 32'd0);
        chk("drop_ready_back", 32'(bus.s_ready), 32'd1);

        // Overflow from beat 3 of a 6-beat packet
        beat(1, 0, 0, 0, 8'h31, 1);
        beat(0, 0, 0, 0, 8'h32, 1);
        beat(0, 0, 0, 1, 8'h33, 0);
        beat(0, 0, 0, 1, 8'h34, 0);
        beat(0, 0, 0, 0, 8'h35, 0);
        chk("ovf_discard_no_wrst", 32'(fifo_wrst), 32'd0);
        beat(0, 1, 0, 0, 8'h36, 0);
        chk("ovf_wrst", 32'(fifo_wrst), 32'd1);
        chk("ovf_rst_wptr", 32'(fifo_rst_wptr), 32'(pkt_start));
        chk("ovf_no_commit", 32'(commit_pulse), 32'd0);
        idle();
        exp_ptr = pkt_start; exp_drop = exp_drop + 16'd1;
        chk("ovf_drop_cnt", 32'(drop_count), 32'(exp_drop));

        // Back-to-back single-beat packets
        for (int i = 0; i < 5; i++) begin
            beat(1, 1, 0, 0, 8'(8'h40 + i), 1);
            commit_check("b2b");
        end
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Commit across pointer wrap (4-bit pointer)
        beat(1, 0, 0, 0, 8'h50, 1);
        for (int i = 1; i < 4; i++) beat(0, 0, 0, 0, 8'(8'h50 + i), 1);
        beat(0, 1, 0, 0, 8'h54, 1);
        commit_check("pre_wrap");
        chk("pre_wrap_at14", 32'(commit_wptr), 32'd14);
        beat(1, 0, 0, 0, 8'h61, 1);
        beat(0, 0, 0, 0, 8'h62, 1);
        beat(0, 1, 0, 0, 8'h63, 1);
        commit_check("wrap");
        chk("wrap_at1", 32'(commit_wptr), 32'd1);

        // Reset in the middle of a packet
        beat(1, 0, 0, 0, 8'h71, 1);
        beat(0, 0, 0, 0, 8'h72, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_wptr", 32'(commit_wptr), 32'd0);
        chk("mid_rst_pkt", 32'(pkt_count), 32'd0);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        chk("mid_rst_pulse", 32'(commit_pulse), 32'd0);
        chk("mid_rst_wrst", 32'(fifo_wrst), 32'd0);
        chk("mid_rst_rst_wptr", 32'(fifo_rst_wptr), 32'd0);
        idle();
        chk("mid_rst_no_wrst_edge", 32'(fifo_wrst), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        exp_ptr = '0; exp_pkt = '0; exp_drop = '0; exp_commit = '0;
        idle();
        beat(1, 1, 0, 0, 8'h81, 1);
        commit_check("post_rst");

        // Drop counter saturation via single-beat filtered packets
        bus.s_valid = 1'b1; bus.s_sof = 1'b1; bus.s_eof = 1'b1;
        bus.s_drop = 1'b1; bus.s_data = 8'hAA;
        repeat (65534) @(posedge clk);
        #1;
        chk("drop_cnt_fffe", 32'(drop_count), 32'h0000_FFFE);
        repeat (1) @(posedge clk);
        #1;
        chk("drop_cnt_ffff", 32'(drop_count), 32'h0000_FFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_cnt_sat", 32'(drop_count), 32'h0000_FFFF);
        chk("drop_sat_pkt_hold", 32'(pkt_count), 32'(exp_pkt));
        bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_eof = 1'b0; bus.s_drop = 1'b0;
        idle();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pkt_ingress_writer.md
PKT_INGRESS_WRITER -- requirements
Module: pkt_ingress_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11: FIFO address width, matching the downstream fifo_sync instance.
REQ-002 SHALL have parameter W_DATA, default 8: payload beat width. FIFO word width is W_DATA+1.
REQ-003 SHALL use one clock and an asynchronous active-low reset, with ports clk and reset_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  upstream beat valid.
REQ-007 s_ready  output  1  beat accepted when s_valid && s_ready.
REQ-008 s_data  input  W_DATA  beat payload.
REQ-009 s_sof  input  1  first beat of packet.
REQ-010 s_eof  input  1  last beat of packet.
REQ-011 s_drop  input  1  filter reject verdict; sampled only on the eof beat.
REQ-012 fifo_wen  output  1  FIFO write enable.
REQ-013 fifo_wdata  output  W_DATA+1  {s_eof, s_data}.
REQ-014 fifo_full  input  1  FIFO full flag.
REQ-015 fifo_wrst  output  1  FIFO write-pointer reset strobe.
REQ-016 fifo_rst_wptr  output  ADDR_WIDTH+1  rewind target.
REQ-017 commit_wptr  output  ADDR_WIDTH+1  write pointer just past the last committed packet.
REQ-018 commit_pulse  output  1  one-cycle strobe on each commit.
REQ-019 pkt_count  output  16  committed packets.
REQ-020 drop_count  output  16  dropped or aborted packets.

Function
REQ-021 SHALL implement a four-state FSM:
- IDLE: waiting for sof.
- RECV: mid-packet.
- DISCARD: sinking the rest of a failed packet.
- REWIND: one cycle, strobing the rewind.
REQ-022 s_ready SHALL be 1 in every state except REWIND. It depends on state only, never on s_valid.
REQ-023 An internal pointer wr_ptr (ADDR_WIDTH+1 bits) SHALL mirror the FIFO wptr:
- increments on fifo_wen && !fifo_full;
- wraps modulo 2^(ADDR_WIDTH+1).
REQ-024 fifo_wen SHALL be combinational. It SHALL equal accepted beat && !fifo_full && !(s_eof && s_drop) && (state==RECV || (state==IDLE && s_sof)).
REQ-025 On an accepted sof beat in IDLE, start_ptr SHALL capture wr_ptr.
REQ-026 IDLE transitions on an accepted sof beat:
- sof without eof, written -> RECV.
- sof with eof, written -> commit, stay IDLE.
- sof with eof and drop -> drop_count++, stay IDLE, nothing written.
REQ-027 In IDLE, a beat without s_sof SHALL be consumed and ignored.
REQ-028 In RECV, s_sof SHALL be treated as ordinary data.
REQ-029 In RECV, an accepted eof beat with !s_drop and !fifo_full SHALL be written. Next edge: commit_wptr <= wr_ptr+1, commit_pulse=1, pkt_count++, state -> IDLE.
REQ-030 In RECV, an accepted eof beat with s_drop SHALL NOT be written; state -> REWIND.
REQ-031 Any accepted beat while fifo_full (overflow) SHALL NOT be written:
- in RECV, or sof in IDLE, without eof -> DISCARD;
- with eof -> REWIND (RECV) or stay IDLE (IDLE sof), with drop_count++.
REQ-032 DISCARD SHALL consume beats without writing; the accepted eof beat -> REWIND.
REQ-033 REWIND SHALL run for exactly one cycle:
- fifo_wrst=1, fifo_rst_wptr=start_ptr;
- wr_ptr <= start_ptr, drop_count++;
- next state -> IDLE.
REQ-034 fifo_rst_wptr SHALL equal start_ptr at all times.
REQ-035 Commit and rewind SHALL never occur in the same cycle.
REQ-036 commit_wptr SHALL change only on commit, so the reader never sees an uncommitted beat.
REQ-037 pkt_count and drop_count SHALL saturate at 16'hFFFF.

Reset
REQ-038 Asserting reset_n low SHALL immediately set:
- state=IDLE, wr_ptr=0, start_ptr=0, commit_wptr=0;
- both counters 0, commit_pulse=0, fifo_wrst=0.
REQ-039 Reset mid-packet SHALL discard the packet without a rewind strobe; the FIFO is reset by the same system reset.
REQ-040 Deassertion SHALL be synchronised externally; the first post-reset edge may accept a beat.

Structure
REQ-041 A shared package pf_ingress_pkg SHALL hold the FSM state enum and the default widths (W_DATA, ADDR_WIDTH).
REQ-042 One sub-module, sat_counter (16-bit saturating increment), SHALL be instantiated twice.

Verification
REQ-043 Single 4-beat packet 0x11..0x14, eof without drop -> 4 writes, then commit_wptr=4, commit_pulse one cycle, pkt_count=1.
REQ-044 3-beat packet with s_drop on eof at wr_ptr=4 -> 2 writes, REWIND cycle with fifo_wrst=1, fifo_rst_wptr=4, drop_count=1, commit_wptr stays 4.
REQ-045 fifo_full forced high on beat 3 of a 6-beat packet -> beats 3-6 unwritten, DISCARD until eof, then one REWIND to start_ptr.
REQ-046 Single-beat sof+eof packets back-to-back for 5 cycles -> 5 writes, 5 commit pulses, s_ready held 1.
REQ-047 Packets committed across wrap at ADDR_WIDTH=3 (wr_ptr 14 -> 1) -> commit_wptr=1 with MSB wrap correct; drop_count preset to 0xFFFF and one more drop -> stays 0xFFFF.
REQ-048 reset_n low during RECV -> all outputs 0 the same cycle, no fifo_wrst strobe; next sof accepted normally.
